// File: rtl/button_pkg.sv
// button_pkg: shared types and default timing constants for button_events.
//   btn_state_t       - FSM state encoding (IDLE, PRESS, REPEAT, HOLD)
//   HOLD_CYCLES_DEF   - default press-to-long-press delay (0.5 s at 50 MHz)
//   REPEAT_CYCLES_DEF - default auto-repeat period (0.1 s at 50 MHz)
//   CNT_W_DEF         - default counter width covering both delays
package button_pkg;
    typedef enum logic [1:0] {IDLE, PRESS, REPEAT, HOLD} btn_state_t;
    localparam int HOLD_CYCLES_DEF   = 25_000_000;
    localparam int REPEAT_CYCLES_DEF = 5_000_000;
    localparam int CNT_W_DEF         = 25;
endpackage

// File: rtl/button_events_if.sv
// button_events_if: button level in, event pulses out.
//   clean_in      - debounced button level, 1 = pressed
//   repeat_en     - allow auto-repeat step pulses after long-press
//   press         - one-cycle pulse on press
//   release_pulse - one-cycle pulse on release
//   long_press    - one-cycle pulse after the hold delay
//   step          - one-cycle pulse on press and on each auto-repeat
//   held          - level, 1 while the button is considered pressed
interface button_events_if;
    logic clean_in;
    logic repeat_en;
    logic press;
    logic release_pulse;
    logic long_press;
    logic step;
    logic held;
    modport master (
        output clean_in, repeat_en,
        input  press, release_pulse, long_press, step, held
    );
    modport slave (
        input  clean_in, repeat_en,
        output press, release_pulse, long_press, step, held
    );
endinterface

// File: rtl/button_events_edge_detect.sv
// edge_detect: rise/fall detection on a glitch-free level.
//   clk, rst - clock and synchronous active-high reset
//   din      - clean input level
//   rise     - din sampled 1 after 0 (combinational, gated by armed)
//   fall     - din sampled 0 after 1 (combinational, gated by armed)
// armed stays low until din has been seen at 0, so a level held through
// reset never reports an edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic prev;
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= din;
            armed <= armed | ~din;
        end
    end

    assign rise = armed & din & ~prev;
    assign fall = armed & ~din & prev;
endmodule

// File: rtl/button_events.sv
// button_events: turns a debounced button level into press/release/long-press/step events.
//   clk, rst - clock and synchronous active-high reset
//   bus      - button_events_if.slave: clean_in, repeat_en in; registered event outputs
// All outputs are registered. A fall always wins over a counter threshold in the
// same cycle, so release suppresses long_press/step.
module button_events
    import button_pkg::*;
#(
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input logic clk,
    input logic rst,
    button_events_if.slave bus
);
    logic rise;
    logic fall;
    btn_state_t state;
    logic [CNT_W-1:0] cnt;
    logic press_q, release_q, long_q, step_q, held_q;
    logic at_hold, at_repeat;

    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.clean_in),
        .rise (rise),
        .fall (fall)
    );

    assign at_hold   = cnt == CNT_W'(HOLD_CYCLES - 1);
    assign at_repeat = cnt == CNT_W'(REPEAT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            step_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            step_q    <= 1'b0;
            if (state != IDLE && fall) begin
                state     <= IDLE;
                cnt       <= '0;
                release_q <= 1'b1;
                held_q    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        state   <= PRESS;
                        cnt     <= '0;
                        press_q <= 1'b1;
                        step_q  <= 1'b1;
                        held_q  <= 1'b1;
                    end
                    PRESS: if (at_hold) begin
                        cnt    <= '0;
                        long_q <= 1'b1;
                        step_q <= bus.repeat_en;
                        state  <= bus.repeat_en ? REPEAT : HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    REPEAT: if (at_repeat) begin
                        cnt    <= '0;
                        step_q <= bus.repeat_en;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_press    = long_q;
    assign bus.step          = step_q;
    assign bus.held          = held_q;
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed and randomized checks of button_events.
module tb_button_events;
    localparam int HOLD = 8;
    localparam int REP  = 3;
    localparam int W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_events_if bus();

    button_events #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: events derived from elapsed time since the press pulse.
    int cyc = 0;
    int pt = 0;
    int el;
    bit seen0 = 0, prevc = 0, pressed = 0, rep_mode = 0;
    logic [4:0] exp_o = '0;
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            seen0 = 0; prevc = 0; pressed = 0; rep_mode = 0; exp_o = '0;
        end else begin
            exp_o = '0;
            if (!pressed) begin
                if (seen0 && bus.clean_in && !prevc) begin
                    pressed = 1; pt = cyc; rep_mode = 0;
                    exp_o[4] = 1; exp_o[1] = 1;
                end
            end else if (seen0 && !bus.clean_in && prevc) begin
                pressed = 0;
                exp_o[3] = 1;
            end else begin
                el = cyc - pt;
                if (el == HOLD) begin
                    exp_o[2] = 1;
                    exp_o[1] = bus.repeat_en;
                    rep_mode = bus.repeat_en;
                end else if (rep_mode && el > HOLD && (el - HOLD) % REP == 0) begin
                    exp_o[1] = bus.repeat_en;
                end
            end
            exp_o[0] = pressed;
            if (!bus.clean_in) seen0 = 1;
            prevc = bus.clean_in;
        end
    end

    function automatic logic [4:0] obs();
        return {bus.press, bus.release_pulse, bus.long_press, bus.step, bus.held};
    endfunction

    task automatic advance(input logic c, input logic r, input logic rs);
        @(negedge clk);
        bus.clean_in  = c;
        bus.repeat_en = r;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int pre_to;
        int hi_from;
        int hi_to;
        logic ren;
        logic [31:0] pm, rm, lm, sm, hm;
    } sc_t;

    localparam logic [31:0] B = 32'd1;
    sc_t sc [5] = '{
        '{-1, 10, 26, 1'b1, B<<11, B<<28, B<<19, (B<<11)|(B<<19)|(B<<22)|(B<<25), (B<<28)-(B<<11)},
        '{-1, 10, 26, 1'b0, B<<11, B<<28, B<<19, B<<11, (B<<28)-(B<<11)},
        '{-1, 10, 13, 1'b1, B<<11, B<<15, 32'd0, B<<11, (B<<15)-(B<<11)},
        '{-1, 10, 17, 1'b1, B<<11, B<<19, 32'd0, B<<11, (B<<19)-(B<<11)},
        '{ 4,  9, 14, 1'b1, B<<10, B<<16, 32'd0, B<<10, (B<<16)-(B<<10)}
    };

    task automatic test_reset();
        advance(1'b0, 1'b1, 1'b1);
        advance(1'b0, 1'b1, 1'b1);
        vectors++;
        if (obs() !== 5'b0) begin
            errors++;
            $display("FAIL reset: got %b expected %b", obs(), 5'b0);
        end
    endtask

    task automatic test_directed();
        logic c;
        logic [4:0] e;
        for (int s = 0; s < 5; s++) begin
            advance(sc[s].pre_to >= 0, sc[s].ren, 1'b1);
            for (int n = 1; n < 32; n++) begin
                c = (n - 1 <= sc[s].pre_to) || (n - 1 >= sc[s].hi_from && n - 1 <= sc[s].hi_to);
                advance(c, sc[s].ren, 1'b0);
                e = {sc[s].pm[n], sc[s].rm[n], sc[s].lm[n], sc[s].sm[n], sc[s].hm[n]};
                vectors++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL directed s%0d cycle %0d {press,rel,long,step,held}: got %b expected %b",
                             s, n, obs(), e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        advance(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) advance(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) advance(1'b1, 1'b1, 1'b0);
        advance(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) advance(i < 7, 1'b1, 1'b0);
            vectors++;
            if (obs() !== 5'b0) begin
                errors++;
                $display("FAIL reset_mid_press step %0d: got %b expected %b", i, obs(), 5'b0);
            end
        end
    endtask

    task automatic test_random();
        logic c = 1'b0;
        logic r = 1'b1;
        int seg = 3;
        advance(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            if (--seg == 0) begin
                c = ~c;
                seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 30);
            end
            if ($urandom_range(0, 19) == 0) r = ~r;
            advance(c, r, $urandom_range(0, 399) == 0);
            vectors++;
            if (obs() !== exp_o) begin
                errors++;
                $display("FAIL random cycle %0d {press,rel,long,step,held}: got %b expected %b",
                         i, obs(), exp_o);
            end
        end
    endtask

    initial begin
        bus.clean_in  = 1'b0;
        bus.repeat_en = 1'b1;
        test_reset();
        test_directed();
        test_reset_mid_press();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
